psram_arbiter: RTL

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_arbiter_if.sv | 51 +++++
 rtl/psram_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if -- bundle of the two requester ports and the memory-side
// command bus around psram_arbiter.
//   a_* : port A (video) request/ack/data
//   b_* : port B (CPU) request/ack/data
//   mem_* : command strobes, address and data to/from the PSRAM memory module
//   busy : arbiter is not idle
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters and memory module)
interface psram_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [23:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_ack;
  logic [15:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic [23:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_ack;
  logic [15:0] b_rdata;

  logic        mem_ready;
  logic        mem_read_strobe;
  logic        mem_write_strobe;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_ready, mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_read_strobe, mem_write_strobe, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_ready, mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_read_strobe, mem_write_strobe, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/psram_arbiter.sv
// psram_arbiter -- two-port (A = video, B = CPU) arbiter in front of a PSRAM
// memory module that exposes a ready/strobe command interface.
// Ports:
//   clk   : system clock, shared with the memory module
//   rst_n : synchronous active-low reset
//   bus   : psram_arbiter_if.slave (requester ports, memory bus, busy)
// Build option:
//   PSRAM_ARB_FIXED_PRIO_EN -- when defined, port A always wins contention;
//   otherwise round-robin with a last_owner bit (A wins first after reset).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a request while the memory is ready
// ISSUE     | one-cycle read or write strobe to the memory
// WAIT_BUSY | waiting for the memory to drop ready (bounded, 4 cycles)
// WAIT_DONE | memory busy; ack the owner when ready returns
module psram_arbiter (
  input logic             clk,
  input logic             rst_n,
  psram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic        latched_we;
  logic [1:0]  tmo_cnt;
  logic [23:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] a_rdata_q;
  logic [15:0] b_rdata_q;
  logic        a_ack_q;
  logic        b_ack_q;
  logic        grant;
  logic        pick_b;
  logic        done;

  // No grant in an ack cycle: the requester still holds req there, and
  // that req belongs to the transaction just finished.
  assign grant = (state == IDLE) && bus.mem_ready && !a_ack_q && !b_ack_q &&
                 (bus.a_req || bus.b_req);
  assign done  = (state == WAIT_DONE) && bus.mem_ready;

`ifdef PSRAM_ARB_FIXED_PRIO_EN
  assign pick_b = !bus.a_req;
`else
  logic last_owner;

  // B wins only when it is alone, or when A owned the previous transaction.
  assign pick_b = !bus.a_req || (bus.b_req && (last_owner == OWN_A));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner <= OWN_B;
    end else if (grant) begin
      last_owner <= pick_b;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.mem_ready) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == 2'd0) begin
          state_nxt = ISSUE;   // strobe was missed, send it again
        end
      end
      WAIT_DONE: if (bus.mem_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner       <= OWN_A;
      latched_we  <= 1'b0;
      tmo_cnt     <= 2'd0;
      mem_addr_q  <= 24'd0;
      mem_wdata_q <= 16'd0;
      a_rdata_q   <= 16'd0;
      b_rdata_q   <= 16'd0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;

      if (grant) begin
        owner       <= pick_b;
        latched_we  <= pick_b ? bus.b_we    : bus.a_we;
        mem_addr_q  <= pick_b ? bus.b_addr  : bus.a_addr;
        mem_wdata_q <= pick_b ? bus.b_wdata : bus.a_wdata;
      end

      // Loaded on every strobe; reaching 0 with ready still high means
      // four WAIT_BUSY cycles passed without the memory taking the command.
      if (state == ISSUE) begin
        tmo_cnt <= 2'd3;
      end else if ((state == WAIT_BUSY) && bus.mem_ready && (tmo_cnt != 2'd0)) begin
        tmo_cnt <= tmo_cnt - 2'd1;
      end

      if (done) begin
        if (owner == OWN_B) begin
          b_ack_q <= 1'b1;
          if (!latched_we) b_rdata_q <= bus.mem_rdata;
        end else begin
          a_ack_q <= 1'b1;
          if (!latched_we) a_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_read_strobe  = (state == ISSUE) && !latched_we;
  assign bus.mem_write_strobe = (state == ISSUE) &&  latched_we;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.a_ack            = a_ack_q;
  assign bus.b_ack            = b_ack_q;
  assign bus.a_rdata          = a_rdata_q;
  assign bus.b_rdata          = b_rdata_q;
  assign bus.busy             = (state != IDLE);

endmodule
